mem_bank_ring: RTL

Parametrised circular sample-capture buffer for the acquisition front end. It continuously records incoming IF samples into a wrap-around RAM bank. On a trigger it records a programmable number of post-trigger samples, then freezes. Frozen contents can be replayed oldest-first, any number of times, over a valid/ready stream to the correlator or host readout path.

---
 rtl/mem_bank_pkg.sv | 19 +
 rtl/mem_bank_sdp_ram.sv | 41 ++++
 rtl/mem_bank_ring.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_pkg.sv
// Shared constants for the circular sample-capture bank: state encoding,
// output FIFO depth and RAM read latency.
package mem_bank_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RECORD = 3'd1;
    localparam logic [2:0] ST_POST   = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_PLAY   = 3'd4;

    localparam int FIFO_DEPTH = 4;
    localparam int RD_LATENCY = 2;

    // Population count of a 4-bit occupancy/in-flight vector.
    function automatic logic [2:0] count_ones4(input logic [3:0] v);
        count_ones4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/mem_bank_sdp_ram.sv
// Simple dual-port sample RAM: synchronous write, read with registered
// address and registered output (two-cycle read latency).
module mem_bank_sdp_ram #(
    parameter int WORD_LENGTH = 24,
    parameter int NUM_WORDS   = 8192,
    parameter int ADDR_WIDTH  = 13
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_we,
    input  logic [ADDR_WIDTH-1:0]  i_waddr,
    input  logic [WORD_LENGTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0]  i_raddr,
    output logic [WORD_LENGTH-1:0] o_rdata
);

    logic [WORD_LENGTH-1:0] r_mem [NUM_WORDS];
    logic [ADDR_WIDTH-1:0]  r_raddr;
    logic [WORD_LENGTH-1:0] r_rdata;

    // Write port; contents deliberately survive reset.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read address register followed by the output data register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_raddr <= '0;
            r_rdata <= '0;
        end else begin
            r_raddr <= i_raddr;
            r_rdata <= r_mem[r_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bank_ring.sv
// Circular capture buffer: records samples until a trigger plus post-count,
// then freezes and replays oldest-first over a credit-fed valid/ready stream.
module mem_bank_ring
    import mem_bank_pkg::*;
#(
    parameter int WORD_LENGTH = 24,
    parameter int NUM_WORDS   = 8192,
    parameter int ADDR_WIDTH  = 13
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_in_valid,
    input  logic [WORD_LENGTH-1:0] i_in_data,
    input  logic                   i_arm,
    input  logic                   i_trigger,
    input  logic [ADDR_WIDTH-1:0]  i_post_count,
    input  logic                   i_play,
    output logic                   o_out_valid,
    output logic [WORD_LENGTH-1:0] o_out_data,
    output logic                   o_out_last,
    input  logic                   i_out_ready,
    output logic [2:0]             o_state,
    output logic [ADDR_WIDTH:0]    o_fill,
    output logic                   o_full
);

    localparam logic [ADDR_WIDTH:0]   N_W       = (ADDR_WIDTH+1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_W     = (ADDR_WIDTH+1)'(1);

    logic [2:0]             r_state, w_state_n;
    logic [ADDR_WIDTH-1:0]  r_wp, w_wp_n, r_rp, w_rp_n;
    logic [ADDR_WIDTH:0]    r_fill, w_fill_n, r_pc, w_pc_n, r_rem, w_rem_n;
    logic                   r_full;
    logic [RD_LATENCY-1:0]  r_rd_vld, r_rd_last;
    logic [FIFO_DEPTH-1:0]  r_fv, w_fv_n, r_fl, w_fl_n;
    logic [WORD_LENGTH-1:0] r_fd [FIFO_DEPTH];
    logic [WORD_LENGTH-1:0] w_fd_n [FIFO_DEPTH];
    logic [WORD_LENGTH-1:0] w_rdata;
    logic                   w_we, w_issue, w_pop, w_credit_ok, w_slot_found;
    logic [ADDR_WIDTH-1:0]  w_wp_inc, w_rp_inc, w_rp0;
    logic [ADDR_WIDTH:0]    w_fill_inc, w_post_clamp, w_wp_ext, w_rp0_ext;

    assign w_we         = i_in_valid && (i_arm || r_state == ST_RECORD || r_state == ST_POST);
    assign w_wp_inc     = (r_wp == LAST_ADDR) ? {ADDR_WIDTH{1'b0}} : r_wp + ADDR_WIDTH'(1);
    assign w_rp_inc     = (r_rp == LAST_ADDR) ? {ADDR_WIDTH{1'b0}} : r_rp + ADDR_WIDTH'(1);
    assign w_fill_inc   = (r_fill == N_W) ? r_fill : r_fill + ONE_W;
    assign w_post_clamp = ({1'b0, i_post_count} > N_W) ? N_W : {1'b0, i_post_count};
    assign w_wp_ext     = {1'b0, r_wp};
    assign w_rp0_ext    = (w_wp_ext >= r_fill) ? (w_wp_ext - r_fill) : (w_wp_ext + N_W - r_fill);
    assign w_rp0        = w_rp0_ext[ADDR_WIDTH-1:0];

    // A read may issue only while FIFO entries plus reads in flight leave a free slot.
    assign w_credit_ok = ({1'b0, count_ones4(r_fv)} + {1'b0, count_ones4({2'b00, r_rd_vld})})
                         < 4'(FIFO_DEPTH);
    assign w_issue     = (r_state == ST_PLAY) && (r_rem != {(ADDR_WIDTH+1){1'b0}}) && w_credit_ok;
    assign w_pop       = r_fv[0] && i_out_ready;

    mem_bank_sdp_ram #(
        .WORD_LENGTH(WORD_LENGTH),
        .NUM_WORDS  (NUM_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_we   (w_we),
        .i_waddr(r_wp),
        .i_wdata(i_in_data),
        .i_raddr(r_rp),
        .o_rdata(w_rdata)
    );

    // Next-state logic for the FSM, pointers and counters; arm overrides every state.
    always_comb begin
        w_state_n = r_state;
        w_wp_n    = r_wp;
        w_fill_n  = r_fill;
        w_pc_n    = r_pc;
        w_rp_n    = r_rp;
        w_rem_n   = r_rem;
        if (i_arm) begin
            w_state_n = ST_RECORD;
            w_pc_n    = '0;
            w_rem_n   = '0;
            if (i_in_valid) begin
                w_wp_n   = w_wp_inc;
                w_fill_n = ONE_W;
            end else begin
                w_fill_n = '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_n = ST_IDLE;
                end
                ST_RECORD: begin
                    if (i_in_valid) begin
                        w_wp_n   = w_wp_inc;
                        w_fill_n = w_fill_inc;
                    end else begin
                        w_wp_n = r_wp;
                    end
                    if (!i_trigger) begin
                        w_state_n = ST_RECORD;
                    end else if (w_post_clamp == {(ADDR_WIDTH+1){1'b0}}) begin
                        w_state_n = ST_HOLD;
                    end else begin
                        w_state_n = ST_POST;
                        w_pc_n    = w_post_clamp;
                    end
                end
                ST_POST: begin
                    if (i_in_valid) begin
                        w_wp_n    = w_wp_inc;
                        w_fill_n  = w_fill_inc;
                        w_pc_n    = r_pc - ONE_W;
                        w_state_n = (r_pc == ONE_W) ? ST_HOLD : ST_POST;
                    end else begin
                        w_pc_n = r_pc;
                    end
                end
                ST_HOLD: begin
                    if (i_play && (r_fill != {(ADDR_WIDTH+1){1'b0}})) begin
                        w_state_n = ST_PLAY;
                        w_rp_n    = w_rp0;
                        w_rem_n   = r_fill;
                    end else begin
                        w_state_n = ST_HOLD;
                    end
                end
                ST_PLAY: begin
                    if (w_issue) begin
                        w_rp_n  = w_rp_inc;
                        w_rem_n = r_rem - ONE_W;
                    end else begin
                        w_rp_n = r_rp;
                    end
                    w_state_n = (w_pop && r_fl[0]) ? ST_HOLD : ST_PLAY;
                end
                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, pointer and counter registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_wp    <= '0;
            r_fill  <= '0;
            r_full  <= 1'b0;
            r_pc    <= '0;
            r_rp    <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_n;
            r_wp    <= w_wp_n;
            r_fill  <= w_fill_n;
            r_full  <= (w_fill_n == N_W);
            r_pc    <= w_pc_n;
            r_rp    <= w_rp_n;
            r_rem   <= w_rem_n;
        end
    end

    // Tags travelling alongside the two-cycle RAM read; arm discards them.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_vld  <= '0;
            r_rd_last <= '0;
        end else if (i_arm) begin
            r_rd_vld  <= '0;
            r_rd_last <= '0;
        end else begin
            r_rd_vld  <= {r_rd_vld[RD_LATENCY-2:0], w_issue};
            r_rd_last <= {r_rd_last[RD_LATENCY-2:0], w_issue && (r_rem == ONE_W)};
        end
    end

    // Shift-style output FIFO: entry 0 is always the head, so outputs come straight from registers.
    always_comb begin
        w_fv_n       = r_fv;
        w_fl_n       = r_fl;
        w_fd_n       = r_fd;
        w_slot_found = 1'b0;
        if (w_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                w_fv_n[i] = r_fv[i+1];
                w_fl_n[i] = r_fl[i+1];
                w_fd_n[i] = r_fd[i+1];
            end
            w_fv_n[FIFO_DEPTH-1] = 1'b0;
        end else begin
            w_fv_n = r_fv;
        end
        if (r_rd_vld[RD_LATENCY-1]) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (!w_slot_found && !w_fv_n[i]) begin
                    w_fv_n[i]    = 1'b1;
                    w_fl_n[i]    = r_rd_last[RD_LATENCY-1];
                    w_fd_n[i]    = w_rdata;
                    w_slot_found = 1'b1;
                end else begin
                    w_slot_found = w_slot_found;
                end
            end
        end else begin
            w_slot_found = 1'b0;
        end
    end

    // Output FIFO registers; arm empties the FIFO but leaves the data words in place.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_fv <= '0;
            r_fl <= '0;
            r_fd <= '{default: '0};
        end else if (i_arm) begin
            r_fv <= '0;
            r_fl <= '0;
            r_fd <= r_fd;
        end else begin
            r_fv <= w_fv_n;
            r_fl <= w_fl_n;
            r_fd <= w_fd_n;
        end
    end

    assign o_out_valid = r_fv[0];
    assign o_out_last  = r_fl[0];
    assign o_out_data  = r_fd[0];
    assign o_state     = r_state;
    assign o_fill      = r_fill;
    assign o_full      = r_full;

endmodule
